// File: rtl/wb_uart_tx_fifo.sv
// Wishbone transmit FIFO in front of uart_tx: first-word-fall-through byte queue plus a status word.
// Define WB_UART_TX_FIFO_BLOCKING_EN to stall DATA writes while full, rather than dropping them and flagging overflow.
module wb_uart_tx_fifo #(
    parameter int Depth = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    input  logic [31:0] wb_data_i,
    input  logic [29:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i
);
    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          ack_q;
    logic [31:0]   rdata_q, rdata_d;

    logic full, empty, acc, pop, push;
    logic data_wr, ctrl_wr, flush, ovf_clr, ovf_set;
    logic unused_bits;

    assign full    = (level_q == LW'(Depth));
    assign empty   = (level_q == '0);
    assign acc     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign pop     = out_valid_o & out_ready_i;
    assign data_wr = acc & wb_we_i & ~wb_addr_i[0] & wb_sel_i[0];
    assign ctrl_wr = acc & wb_we_i &  wb_addr_i[0] & wb_sel_i[0];
    assign flush   = ctrl_wr & wb_data_i[0];
    assign ovf_clr = ctrl_wr & wb_data_i[1];
    // A write to a full FIFO still fits when the head leaves in the same cycle.
    assign push    = data_wr & (~full | pop);

`ifdef WB_UART_TX_FIFO_BLOCKING_EN
    assign wb_stall_o = wb_cyc_i & wb_stb_i & wb_we_i & ~wb_addr_i[0] & wb_sel_i[0]
                        & full & ~out_ready_i;
    assign ovf_set    = 1'b0;
`else
    assign wb_stall_o = 1'b0;
    assign ovf_set    = data_wr & full & ~pop;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        rdata_d    = '0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(push) - LW'(pop);
        end
        if (ovf_clr)      overflow_d = 1'b0;
        else if (ovf_set) overflow_d = 1'b1;
        // Read data reflects state before this cycle's push/pop.
        if (acc & ~wb_we_i) begin
            if (wb_addr_i[0]) rdata_d = {21'b0, overflow_q, full, empty, 8'(level_q)};
            else              rdata_d = {23'b0, ~full, 8'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            ack_q      <= acc;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wb_data_i[7:0];
    end

    assign out_valid_o = ~empty;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign wb_ack_o    = ack_q;
    assign wb_data_o   = rdata_q;
    assign wb_err_o    = 1'b0;
    assign unused_bits = ^{wb_data_i[31:8], wb_addr_i[29:1], wb_sel_i[3:1]};
endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// Bench for wb_uart_tx_fifo: queue-based model checked every cycle plus directed literal checks.
module tb_wb_uart_tx_fifo;
    localparam int DEPTH = 16;
`ifdef WB_UART_TX_FIFO_BLOCKING_EN
    localparam logic [31:0] OVF = 32'h000;
`else
    localparam logic [31:0] OVF = 32'h400;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_rdata;
    logic        wb_ack, wb_stall, wb_err;
    logic [31:0] wb_wdata = '0;
    logic [29:0] wb_addr = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    byte unsigned q[$];
    bit          ovf_m = 1'b0;
    bit          exp_ack = 1'b0;
    bit          exp_rd = 1'b0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    wb_uart_tx_fifo #(.Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_data_o(wb_rdata), .wb_ack_o(wb_ack), .wb_stall_o(wb_stall), .wb_err_o(wb_err),
        .wb_data_i(wb_wdata), .wb_addr_i(wb_addr), .wb_sel_i(wb_sel),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit stall_m();
`ifdef WB_UART_TX_FIFO_BLOCKING_EN
        return wb_cyc && wb_stb && wb_we && !wb_addr[0] && wb_sel[0]
               && (q.size() == DEPTH) && !out_ready;
`else
        return 1'b0;
`endif
    endfunction

    // Model: FIFO as a queue, status built from its size.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            ovf_m = 1'b0; exp_ack = 1'b0; exp_rd = 1'b0;
        end else begin
            bit full_m, acc, do_pop;
            full_m = (q.size() == DEPTH);
            acc    = wb_cyc && wb_stb && !stall_m();
            do_pop = (q.size() != 0) && out_ready;
            exp_ack = acc;
            exp_rd  = acc && !wb_we;
            if (exp_rd) begin
                if (wb_addr[0])
                    exp_rdata = q.size() + (q.size() == 0 ? 32'h100 : 0)
                              + (full_m ? 32'h200 : 0) + (ovf_m ? 32'h400 : 0);
                else
                    exp_rdata = full_m ? 32'h0 : 32'h100;
            end
            if (acc && wb_we && wb_sel[0]) begin
                if (wb_addr[0]) begin
                    if (wb_wdata[0]) begin q.delete(); do_pop = 1'b0; end
                    if (wb_wdata[1]) ovf_m = 1'b0;
                end else if (!full_m || do_pop) begin
                    if (do_pop) void'(q.pop_front());
                    do_pop = 1'b0;
                    q.push_back(wb_wdata[7:0]);
                end else begin
                    ovf_m = 1'b1;
                end
            end
            if (do_pop) void'(q.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("ack", wb_ack, exp_ack);
            if (exp_ack && exp_rd) chk("rdata", wb_rdata, exp_rdata);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) chk("out_data", out_data, q[0]);
            chk("stall", wb_stall, stall_m());
            chk("err", wb_err, 0);
            chk("level_bound", q.size() <= DEPTH, 1);
        end
    end

    // Bus tasks are entered and left 1 time unit after a rising edge.
    task automatic wb_access(input logic we, input logic a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic st;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_addr = {29'b0, a}; wb_wdata = d; wb_sel = s;
        n = 0;
        do begin
            @(negedge clk); st = wb_stall;
            @(posedge clk); n++;
        end while (st && n < 200);
        if (st) begin
            total++; bad++;
            $display("FAIL access_timeout: got stall=1 expected accept within 200 cycles");
        end
        #1 wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic a, input logic [31:0] d, input logic [3:0] s = 4'h1);
        wb_access(1'b1, a, d, s);
        $display("write addr=%0d data=%08h sel=%h", a, d, s);
    endtask

    task automatic wb_read(input logic a, output logic [31:0] d);
        wb_access(1'b0, a, 32'h0, 4'hF);
        @(negedge clk); d = wb_rdata;
        @(posedge clk); #1;
        $display("read  addr=%0d data=%08h", a, d);
    endtask

    logic [31:0] rd;

    initial begin
        // Reset state.
        @(negedge clk);
        chk("rst_ack", wb_ack, 0);
        chk("rst_rdata", wb_rdata, 0);
        chk("rst_valid", out_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write.
        wb_write(0, 32'h41);
        @(negedge clk);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h41);
        @(posedge clk); #1;
        wb_read(1, rd); chk("single_status", rd, 32'h001);
        wb_write(0, 32'h99, 4'h0);
        wb_read(1, rd); chk("sel0_status", rd, 32'h001);
        wb_write(1, 32'h1);

        // Fill to full, then one more.
        for (int i = 0; i < DEPTH; i++) wb_write(0, i);
        wb_read(1, rd); chk("full_status", rd, 32'h210);
        wb_read(0, rd); chk("full_data_rd", rd, 32'h000);
`ifdef WB_UART_TX_FIFO_BLOCKING_EN
        fork
            wb_write(0, 32'hFF);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        wb_read(1, rd); chk("blocked_status", rd, 32'h210);
`else
        wb_write(0, 32'hFF);
        wb_read(1, rd); chk("overflow_status", rd, 32'h610);
`endif

        // Drain order.
        wb_write(1, 32'h3);
        for (int i = 0; i < DEPTH; i++) wb_write(0, i);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, i);
        end
        @(negedge clk); chk("drain_empty", out_valid, 0);
        @(posedge clk); #1 out_ready = 1'b0;
        wb_read(1, rd); chk("drain_status", rd, 32'h100);

        // Push and pop together at full.
        for (int i = 0; i < DEPTH; i++) wb_write(0, i);
        out_ready = 1'b1;
        fork
            wb_write(0, 32'h55);
            begin @(posedge clk); #1 out_ready = 1'b0; end
        join
        wb_read(1, rd); chk("pushpop_status", rd, 32'h210);
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk); chk("pushpop_head", out_data, 8'h55);
        @(posedge clk); #1;
        wb_write(1, 32'h1);

        // Wrap-around at half full with one push and one pop per cycle.
        for (int i = 0; i < DEPTH / 2; i++) wb_write(0, 32'hA0 + i);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) wb_write(0, (i * 7 + 3) & 8'hFF);
        out_ready = 1'b0;
        wb_read(1, rd); chk("wrap_status", rd, 32'h008);
        wb_write(1, 32'h1);

        // Flush and overflow clear.
        for (int i = 0; i < DEPTH; i++) wb_write(0, 32'hC0 + i);
`ifndef WB_UART_TX_FIFO_BLOCKING_EN
        wb_write(0, 32'hEE);
`endif
        wb_read(1, rd); chk("pre_flush_status", rd, OVF | 32'h210);
        wb_write(1, 32'h1);
        wb_read(1, rd); chk("flush_keeps_ovf", rd, OVF | 32'h100);
        for (int i = 0; i < 5; i++) wb_write(0, 32'h30 + i);
        wb_read(1, rd); chk("five_status", rd, OVF | 32'h005);
        wb_write(1, 32'h3);
        wb_read(1, rd); chk("flush_clear_status", rd, 32'h100);

        // Reset mid-burst.
        for (int i = 0; i < 3; i++) wb_write(0, 32'h60 + i);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ack", wb_ack, 0);
        chk("async_rst_valid", out_valid, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        wb_write(0, 32'h41);
        wb_read(1, rd); chk("post_rst_status", rd, 32'h001);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
